// File: rtl/yarvi_io.sv
// yarvi_io: memory-mapped byte I/O bridge between the YARVI core I/O bus and a
// host byte stream. Two circular-buffer FIFOs (core->host TX, host->core RX),
// a DATA register (push TX / pop RX) and a STATUS register with a sticky
// TX overflow flag.
//
// Handshake semantics (both host ports): a byte transfers on a rising clock
// edge where valid && ready are both high; valid/data are held by the source
// until that edge, and ready never depends combinationally on valid.
module yarvi_io #(
    parameter logic [31:0] BASE_ADDR     = 32'h1000_0000,
    parameter int          TX_DEPTH_LOG2 = 2,
    parameter int          RX_DEPTH_LOG2 = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [29:0] io_address,
    input  logic [31:0] io_wdata,
    input  logic [3:0]  io_we,
    input  logic        io_re,
    output logic [31:0] io_rdata,
    output logic        irq,
    output logic        rx_ready,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        tx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data
);

    localparam int TXN      = TX_DEPTH_LOG2;
    localparam int RXN      = RX_DEPTH_LOG2;
    localparam int TX_DEPTH = 1 << TXN;
    localparam int RX_DEPTH = 1 << RXN;

    localparam logic [TXN:0]   TX_CAP     = (TXN+1)'(TX_DEPTH);
    localparam logic [RXN:0]   RX_CAP     = (RXN+1)'(RX_DEPTH);
    localparam logic [TXN:0]   TX_CNT_ONE = (TXN+1)'(1);
    localparam logic [RXN:0]   RX_CNT_ONE = (RXN+1)'(1);
    localparam logic [TXN-1:0] TX_PTR_ONE = TXN'(1);
    localparam logic [RXN-1:0] RX_PTR_ONE = RXN'(1);

    // Word addresses of the two registers.
    localparam logic [29:0] REG_DATA   = BASE_ADDR[31:2];
    localparam logic [29:0] REG_STATUS = BASE_ADDR[31:2] + 30'd1;

    // FIFO storage (not reset) and bookkeeping registers.
    logic [7:0]     r_tx_mem [TX_DEPTH];
    logic [7:0]     r_rx_mem [RX_DEPTH];
    logic [TXN-1:0] r_tx_rptr;
    logic [TXN-1:0] r_tx_wptr;
    logic [TXN:0]   r_tx_count;
    logic [RXN-1:0] r_rx_rptr;
    logic [RXN-1:0] r_rx_wptr;
    logic [RXN:0]   r_rx_count;
    logic           r_tx_ovf;
    logic [31:0]    r_rdata;
    logic           r_alive;

    logic        w_sel_data;
    logic        w_sel_status;
    logic        w_tx_full;
    logic        w_tx_empty;
    logic        w_rx_full;
    logic        w_rx_empty;
    logic        w_tx_wr;
    logic        w_tx_push;
    logic        w_tx_pop;
    logic        w_ovf_set;
    logic        w_ovf_clr;
    logic        w_rx_push;
    logic        w_rx_pop;
    logic [31:0] w_rdata_next;
    logic        w_unused_bits;

    assign w_sel_data   = (io_address == REG_DATA);
    assign w_sel_status = (io_address == REG_STATUS);

    assign w_tx_full  = (r_tx_count == TX_CAP);
    assign w_tx_empty = (r_tx_count == '0);
    assign w_rx_full  = (r_rx_count == RX_CAP);
    assign w_rx_empty = (r_rx_count == '0);

    // Fullness is judged on pre-cycle state, so a same-cycle host pop does
    // not rescue a write to a full TX FIFO.
    assign w_tx_wr   = w_sel_data & io_we[0];
    assign w_tx_push = w_tx_wr & ~w_tx_full;
    assign w_ovf_set = w_tx_wr & w_tx_full;
    assign w_ovf_clr = w_sel_status & io_we[0] & io_wdata[2];
    assign w_tx_pop  = ~w_tx_empty & tx_ready;

    assign w_rx_push = rx_valid & rx_ready;
    assign w_rx_pop  = w_sel_data & io_re & ~w_rx_empty;

    // Host-facing outputs come from registered state only.
    assign tx_valid = ~w_tx_empty;
    assign tx_data  = w_tx_empty ? 8'h00 : r_tx_mem[r_tx_rptr];
    assign rx_ready = r_alive & ~w_rx_full;
    assign irq      = ~w_rx_empty;
    assign io_rdata = r_rdata;

    assign w_unused_bits = &{1'b0, io_wdata[31:8], io_we[3:1]};

    // Read-data mux built from pre-cycle state.
    always_comb begin
        w_rdata_next = 32'h0;
        if (w_sel_data) begin
            if (!w_rx_empty) begin
                w_rdata_next = {23'b0, 1'b1, r_rx_mem[r_rx_rptr]};
            end
        end else if (w_sel_status) begin
            w_rdata_next = {8'h00, 8'(r_rx_count), 8'(r_tx_count),
                            5'b0, r_tx_ovf, ~w_rx_empty, w_tx_full};
        end
    end

    // FIFO storage writes.
    always_ff @(posedge clock) begin
        if (w_tx_push) begin
            r_tx_mem[r_tx_wptr] <= io_wdata[7:0];
        end
        if (w_rx_push) begin
            r_rx_mem[r_rx_wptr] <= rx_data;
        end
    end

    // TX FIFO pointers and occupancy.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_tx_rptr  <= '0;
            r_tx_wptr  <= '0;
            r_tx_count <= '0;
        end else begin
            if (w_tx_push) r_tx_wptr <= r_tx_wptr + TX_PTR_ONE;
            if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + TX_PTR_ONE;
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_count <= r_tx_count + TX_CNT_ONE;
                2'b01:   r_tx_count <= r_tx_count - TX_CNT_ONE;
                default: r_tx_count <= r_tx_count;
            endcase
        end
    end

    // RX FIFO pointers and occupancy.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rx_rptr  <= '0;
            r_rx_wptr  <= '0;
            r_rx_count <= '0;
        end else begin
            if (w_rx_push) r_rx_wptr <= r_rx_wptr + RX_PTR_ONE;
            if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + RX_PTR_ONE;
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_count <= r_rx_count + RX_CNT_ONE;
                2'b01:   r_rx_count <= r_rx_count - RX_CNT_ONE;
                default: r_rx_count <= r_rx_count;
            endcase
        end
    end

    // Sticky TX overflow flag; a clear beats a same-cycle set.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_tx_ovf <= 1'b0;
        end else if (w_ovf_clr) begin
            r_tx_ovf <= 1'b0;
        end else if (w_ovf_set) begin
            r_tx_ovf <= 1'b1;
        end
    end

    // Registered read data, updated only on a read strobe.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rdata <= 32'h0;
        end else if (io_re) begin
            r_rdata <= w_rdata_next;
        end
    end

    // Keeps rx_ready low until the first edge after reset release.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_alive <= 1'b0;
        end else begin
            r_alive <= 1'b1;
        end
    end

endmodule
